// File: rtl/opdiv_radix2.sv
// Sequential radix-2 restoring divider: DIV/DIVU/REM/REMU, one op in flight.
// Optional OPDIV_EARLY_TERM_EN starts iteration at the dividend's leading one.
module opdiv_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE, PREP, CALC, FIXUP, DONE
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic             sa_q;
  logic             sb_q;
  logic [KW-1:0]    k_q;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             ovf;
  logic [KW-1:0]    k_init;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);

  always_comb begin
    is_signed = ~op_q[0];
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    div_zero  = (b_q == '0);
    ovf       = is_signed
              && (a_q == {1'b1, {(WIDTH-1){1'b0}}})
              && (b_q == '1);
`ifdef OPDIV_EARLY_TERM_EN
    k_init = '0;
    for (int i = 0; i < WIDTH; i++)
      if (a_mag[i]) k_init = KW'(i);
`else
    k_init = KW'(WIDTH-1);
`endif
    // rem < |b| always, so the shifted value never needs more than WIDTH+1 bits
    t     = {rem_q, a_q[k_q]};
    diff  = t - {1'b0, b_q};
    ge    = ~diff[WIDTH];
    q_fix = (sa_q ^ sb_q) ? -quo_q : quo_q;
    r_fix = sa_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      k_q      <= '0;
      result_o <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid_i) begin
            op_q  <= op_i;
            a_q   <= a_i;
            b_q   <= b_i;
            state <= PREP;
          end
        end
        PREP: begin
          sa_q <= a_neg;
          sb_q <= b_neg;
          if (div_zero) begin
            result_o <= op_q[1] ? a_q : '1;
            state    <= DONE;
          end else if (ovf) begin
            result_o <= op_q[1] ? '0 : a_q;
            state    <= DONE;
          end else begin
            a_q   <= a_mag;
            b_q   <= b_mag;
            rem_q <= '0;
            quo_q <= '0;
            k_q   <= k_init;
            state <= CALC;
          end
        end
        CALC: begin
          rem_q      <= ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
          quo_q[k_q] <= ge;
          if (k_q == '0) state <= FIXUP;
          else           k_q   <= k_q - 1'b1;
        end
        FIXUP: begin
          result_o <= op_q[1] ? r_fix : q_fix;
          state    <= DONE;
        end
        DONE: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
